// File: rtl/csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl
//
// Trap / return sequencer for the machine-mode CSR file.
//
// At the commit boundary (IDLE state only) it detects a synchronous
// exception, a pending enabled timer or software interrupt, or an MRET.
//
// A trap is then played out as a fixed sequence with one CSR write per cycle:
//   EPC -> CAUSE -> STATUS -> JUMP -> IDLE
// An MRET is played out as a single cycle:
//   MRET -> IDLE
// This cycle redirects fetch and pops the mstatus IE stack.
//
// While the sequence runs, the pipeline is stalled and instruction-originated
// CSR writes are blocked. The dedicated write ports are therefore the only
// CSR writers.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   commit_*_i, exc_*_i,
//   mret_i                    commit-boundary status of the retiring instr
//   mstatus_ie_i, mie_*_i     interrupt enables from the CSR file
//   irq_timer_i, irq_soft_i   level interrupt pending lines
//   mtvec_i, mepc_i           live trap vector / exception PC
//   we_mepc_o / wdata_mepc_o  mepc write port
//   we_mcause_o /
//   wdata_mcause_o            mcause write port
//   exception_mie_req_o       mstatus IE-stack push
//   mret_restore_o            mstatus IE-stack pop
//   csr_we_block_o            gate for instruction CSR writes
//   stall_o                   pipeline freeze
//   redirect_valid_o /
//   redirect_pc_o             one-cycle fetch redirect
//   busy_o                    sequencer not idle
// ---------------------------------------------------------------------------
module csr_trap_ctrl #(
    parameter int XLEN    = 64,
    parameter int CAUSE_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               commit_valid_i,
    input  logic [XLEN-1:0]    commit_pc_i,
    input  logic               exc_valid_i,
    input  logic [CAUSE_W-1:0] exc_cause_i,
    input  logic               mret_i,
    input  logic               mstatus_ie_i,
    input  logic               mie_mtie_i,
    input  logic               mie_msie_i,
    input  logic               irq_timer_i,
    input  logic               irq_soft_i,
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic [XLEN-1:0]    mepc_i,
    output logic               we_mepc_o,
    output logic [XLEN-1:0]    wdata_mepc_o,
    output logic               we_mcause_o,
    output logic [XLEN-1:0]    wdata_mcause_o,
    output logic               exception_mie_req_o,
    output logic               mret_restore_o,
    output logic               csr_we_block_o,
    output logic               stall_o,
    output logic               redirect_valid_o,
    output logic [XLEN-1:0]    redirect_pc_o,
    output logic               busy_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EPC    = 3'd1,
        CAUSE  = 3'd2,
        STATUS = 3'd3,
        JUMP   = 3'd4,
        MRET   = 3'd5
    } state_t;

    // Trap vector is forced to 4-byte alignment (direct mode).
    localparam logic [XLEN-1:0] VEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_t              state_reg;
    logic [CAUSE_W-1:0]  code_reg;
    logic                intr_reg;

    logic                we_mepc_reg;
    logic [XLEN-1:0]     wdata_mepc_reg;
    logic                we_mcause_reg;
    logic [XLEN-1:0]     wdata_mcause_reg;
    logic                mie_req_reg;
    logic                mret_restore_reg;
    logic                redirect_valid_reg;
    logic                busy_reg;
    logic                block_reg;

    // ---------------------------------------------------------------------
    // Detection (only meaningful in IDLE)
    // ---------------------------------------------------------------------
    logic                timer_hit;
    logic                soft_hit;
    logic                trap_take;
    logic                mret_take;
    logic [CAUSE_W-1:0]  code_next;
    logic                intr_next;

    always_comb begin
        timer_hit = mstatus_ie_i & mie_mtie_i & irq_timer_i;
        soft_hit  = mstatus_ie_i & mie_msie_i & irq_soft_i;

        // rst is folded in so the combinational stall is also quiet under reset.
        trap_take = rst & (state_reg == IDLE) & commit_valid_i &
                    (exc_valid_i | timer_hit | soft_hit);

        // Any taken trap (exception or interrupt) overrides a coincident MRET.
        mret_take = rst & (state_reg == IDLE) & commit_valid_i & mret_i &
                    ~(exc_valid_i | timer_hit | soft_hit);

        // Priority: exception > timer > software.
        if (exc_valid_i) begin
            code_next = exc_cause_i;
        end else if (timer_hit) begin
            code_next = CAUSE_W'(7);
        end else begin
            code_next = CAUSE_W'(3);
        end
        intr_next = ~exc_valid_i;
    end

    // ---------------------------------------------------------------------
    // Sequencer with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg          <= IDLE;
            code_reg           <= '0;
            intr_reg           <= 1'b0;
            we_mepc_reg        <= 1'b0;
            wdata_mepc_reg     <= '0;
            we_mcause_reg      <= 1'b0;
            wdata_mcause_reg   <= '0;
            mie_req_reg        <= 1'b0;
            mret_restore_reg   <= 1'b0;
            redirect_valid_reg <= 1'b0;
            busy_reg           <= 1'b0;
            block_reg          <= 1'b0;
        end else begin
            // Strobes and their data are single-cycle by default.
            we_mepc_reg        <= 1'b0;
            wdata_mepc_reg     <= '0;
            we_mcause_reg      <= 1'b0;
            wdata_mcause_reg   <= '0;
            mie_req_reg        <= 1'b0;
            mret_restore_reg   <= 1'b0;
            redirect_valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (trap_take) begin
                        // The commit PC is captured here directly into the mepc
                        // write data; nothing later reads commit_pc_i.
                        state_reg      <= EPC;
                        code_reg       <= code_next;
                        intr_reg       <= intr_next;
                        we_mepc_reg    <= 1'b1;
                        wdata_mepc_reg <= commit_pc_i;
                        busy_reg       <= 1'b1;
                        block_reg      <= 1'b1;
                    end else if (mret_take) begin
                        state_reg          <= MRET;
                        redirect_valid_reg <= 1'b1;
                        mret_restore_reg   <= 1'b1;
                        busy_reg           <= 1'b1;
                        block_reg          <= 1'b1;
                    end
                end
                EPC: begin
                    state_reg        <= CAUSE;
                    we_mcause_reg    <= 1'b1;
                    wdata_mcause_reg <= {intr_reg, {(XLEN-1-CAUSE_W){1'b0}}, code_reg};
                end
                CAUSE: begin
                    state_reg   <= STATUS;
                    mie_req_reg <= 1'b1;
                end
                STATUS: begin
                    state_reg          <= JUMP;
                    redirect_valid_reg <= 1'b1;
                end
                JUMP, MRET: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    block_reg <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    block_reg <= 1'b0;
                end
            endcase
        end
    end

    // Redirect target follows the live CSR value during the redirect cycle,
    // so a CSR value that settles late is still honoured.
    always_comb begin
        redirect_pc_o = '0;
        case (state_reg)
            JUMP:    redirect_pc_o = mtvec_i & VEC_MASK;
            MRET:    redirect_pc_o = mepc_i;
            default: redirect_pc_o = '0;
        endcase
    end

    assign we_mepc_o           = we_mepc_reg;
    assign wdata_mepc_o        = wdata_mepc_reg;
    assign we_mcause_o         = we_mcause_reg;
    assign wdata_mcause_o      = wdata_mcause_reg;
    assign exception_mie_req_o = mie_req_reg;
    assign mret_restore_o      = mret_restore_reg;
    assign redirect_valid_o    = redirect_valid_reg;
    assign busy_o              = busy_reg;
    assign csr_we_block_o      = block_reg;
    assign stall_o             = busy_reg | trap_take | mret_take;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_trap_ctrl
//
// Directed scenarios followed by random traffic. Every cycle is compared
// against a behavioural model that expresses each taken trap or MRET as a
// queue of expected per-cycle output vectors.
// ---------------------------------------------------------------------------
module tb_csr_trap_ctrl;
    localparam int XLEN    = 64;
    localparam int CAUSE_W = 5;

    logic               clk;
    logic               rst;
    logic               commit_valid_i;
    logic [XLEN-1:0]    commit_pc_i;
    logic               exc_valid_i;
    logic [CAUSE_W-1:0] exc_cause_i;
    logic               mret_i;
    logic               mstatus_ie_i;
    logic               mie_mtie_i;
    logic               mie_msie_i;
    logic               irq_timer_i;
    logic               irq_soft_i;
    logic [XLEN-1:0]    mtvec_i;
    logic [XLEN-1:0]    mepc_i;
    logic               we_mepc_o;
    logic [XLEN-1:0]    wdata_mepc_o;
    logic               we_mcause_o;
    logic [XLEN-1:0]    wdata_mcause_o;
    logic               exception_mie_req_o;
    logic               mret_restore_o;
    logic               csr_we_block_o;
    logic               stall_o;
    logic               redirect_valid_o;
    logic [XLEN-1:0]    redirect_pc_o;
    logic               busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    csr_trap_ctrl #(.XLEN(XLEN), .CAUSE_W(CAUSE_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .commit_valid_i      (commit_valid_i),
        .commit_pc_i         (commit_pc_i),
        .exc_valid_i         (exc_valid_i),
        .exc_cause_i         (exc_cause_i),
        .mret_i              (mret_i),
        .mstatus_ie_i        (mstatus_ie_i),
        .mie_mtie_i          (mie_mtie_i),
        .mie_msie_i          (mie_msie_i),
        .irq_timer_i         (irq_timer_i),
        .irq_soft_i          (irq_soft_i),
        .mtvec_i             (mtvec_i),
        .mepc_i              (mepc_i),
        .we_mepc_o           (we_mepc_o),
        .wdata_mepc_o        (wdata_mepc_o),
        .we_mcause_o         (we_mcause_o),
        .wdata_mcause_o      (wdata_mcause_o),
        .exception_mie_req_o (exception_mie_req_o),
        .mret_restore_o      (mret_restore_o),
        .csr_we_block_o      (csr_we_block_o),
        .stall_o             (stall_o),
        .redirect_valid_o    (redirect_valid_o),
        .redirect_pc_o       (redirect_pc_o),
        .busy_o              (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected output vector for one non-idle cycle.
    // pc_src: 0 = no redirect, 1 = aligned mtvec, 2 = mepc.
    typedef struct {
        logic            we_mepc;
        logic [XLEN-1:0] wdata_mepc;
        logic            we_mcause;
        logic [XLEN-1:0] wdata_mcause;
        logic            mie_req;
        logic            mret_restore;
        logic            redirect_valid;
        int              pc_src;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t blank();
        exp_t e;
        e.we_mepc        = 1'b0;
        e.wdata_mepc     = '0;
        e.we_mcause      = 1'b0;
        e.wdata_mcause   = '0;
        e.mie_req        = 1'b0;
        e.mret_restore   = 1'b0;
        e.redirect_valid = 1'b0;
        e.pc_src         = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".we_mepc"},   64'(we_mepc_o), 64'd0);
        chk({tag, ".wd_mepc"},   wdata_mepc_o, 64'd0);
        chk({tag, ".we_mcause"}, 64'(we_mcause_o), 64'd0);
        chk({tag, ".wd_mcause"}, wdata_mcause_o, 64'd0);
        chk({tag, ".mie_req"},   64'(exception_mie_req_o), 64'd0);
        chk({tag, ".mret_rst"},  64'(mret_restore_o), 64'd0);
        chk({tag, ".block"},     64'(csr_we_block_o), 64'd0);
        chk({tag, ".stall"},     64'(stall_o), 64'd0);
        chk({tag, ".redir_v"},   64'(redirect_valid_o), 64'd0);
        chk({tag, ".redir_pc"},  redirect_pc_o, 64'd0);
        chk({tag, ".busy"},      64'(busy_o), 64'd0);
    endtask

    // Compare all outputs for the current cycle against the model, then let
    // the model react to a detection in this cycle.
    task automatic check_now(input string tag);
        exp_t            e;
        logic            idle_m;
        logic            tmr;
        logic            sft;
        logic            trap;
        logic            mr;
        logic [XLEN-1:0] rpc;
        logic [XLEN-1:0] code;
        logic            intr;

        idle_m = (exp_q.size() == 0);
        tmr    = mstatus_ie_i & mie_mtie_i & irq_timer_i;
        sft    = mstatus_ie_i & mie_msie_i & irq_soft_i;
        trap   = 1'b0;
        mr     = 1'b0;
        if (idle_m) begin
            e    = blank();
            trap = commit_valid_i & (exc_valid_i | tmr | sft);
            mr   = commit_valid_i & mret_i & !trap;
        end else begin
            e = exp_q.pop_front();
        end

        if (e.pc_src == 1)      rpc = (mtvec_i / 4) * 4;
        else if (e.pc_src == 2) rpc = mepc_i;
        else                    rpc = '0;

        chk({tag, ".we_mepc"},   64'(we_mepc_o), 64'(e.we_mepc));
        chk({tag, ".wd_mepc"},   wdata_mepc_o, e.wdata_mepc);
        chk({tag, ".we_mcause"}, 64'(we_mcause_o), 64'(e.we_mcause));
        chk({tag, ".wd_mcause"}, wdata_mcause_o, e.wdata_mcause);
        chk({tag, ".mie_req"},   64'(exception_mie_req_o), 64'(e.mie_req));
        chk({tag, ".mret_rst"},  64'(mret_restore_o), 64'(e.mret_restore));
        chk({tag, ".redir_v"},   64'(redirect_valid_o), 64'(e.redirect_valid));
        chk({tag, ".redir_pc"},  redirect_pc_o, rpc);
        chk({tag, ".busy"},      64'(busy_o), 64'(!idle_m));
        chk({tag, ".block"},     64'(csr_we_block_o), 64'(!idle_m));
        chk({tag, ".stall"},     64'(stall_o), idle_m ? 64'(trap | mr) : 64'd1);

        if (trap) begin
            if (exc_valid_i)  code = 64'(exc_cause_i);
            else if (tmr)     code = 64'd7;
            else              code = 64'd3;
            intr = !exc_valid_i;
            e = blank(); e.we_mepc = 1'b1; e.wdata_mepc = commit_pc_i; exp_q.push_back(e);
            e = blank(); e.we_mcause = 1'b1;
            e.wdata_mcause = intr ? (64'h8000_0000_0000_0000 + code) : code;
            exp_q.push_back(e);
            e = blank(); e.mie_req = 1'b1; exp_q.push_back(e);
            e = blank(); e.redirect_valid = 1'b1; e.pc_src = 1; exp_q.push_back(e);
        end else if (mr) begin
            e = blank(); e.redirect_valid = 1'b1; e.mret_restore = 1'b1; e.pc_src = 2;
            exp_q.push_back(e);
        end
        $display("[%0t] %s busy=%0b stall=%0b we_mepc=%0b we_mcause=%0b mie=%0b mret=%0b redir=%0b pc=%h",
                 $time, tag, busy_o, stall_o, we_mepc_o, we_mcause_o,
                 exception_mie_req_o, mret_restore_o, redirect_valid_o, redirect_pc_o);
    endtask

    task automatic tick(input string tag);
        #1;
        check_now(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_commit();
        commit_valid_i = 1'b0;
        exc_valid_i    = 1'b0;
        exc_cause_i    = '0;
        mret_i         = 1'b0;
        commit_pc_i    = '0;
    endtask

    task automatic set_idle();
        clear_commit();
        mstatus_ie_i = 1'b0;
        mie_mtie_i   = 1'b0;
        mie_msie_i   = 1'b0;
        irq_timer_i  = 1'b0;
        irq_soft_i   = 1'b0;
        mtvec_i      = 64'h8000_0100;
        mepc_i       = 64'h0;
    endtask

    initial begin
        rst = 1'b0;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // --- Exception, cause 2 ---
        commit_valid_i = 1'b1; exc_valid_i = 1'b1; exc_cause_i = 5'd2;
        commit_pc_i = 64'h8000_0010;
        tick("exc2_det");
        clear_commit();
        chk("exc2_mepc_we", 64'(we_mepc_o), 64'd1);
        chk("exc2_mepc", wdata_mepc_o, 64'h8000_0010);
        tick("exc2_epc");
        chk("exc2_mcause", wdata_mcause_o, 64'h2);
        tick("exc2_cause");
        chk("exc2_mie", 64'(exception_mie_req_o), 64'd1);
        tick("exc2_status");
        chk("exc2_redir", redirect_pc_o, 64'h8000_0100);
        tick("exc2_jump");
        chk("exc2_idle", 64'(busy_o), 64'd0);

        // --- Timer beats software ---
        mstatus_ie_i = 1'b1; mie_mtie_i = 1'b1; irq_timer_i = 1'b1;
        mie_msie_i = 1'b1; irq_soft_i = 1'b1;
        commit_valid_i = 1'b1; commit_pc_i = 64'h8000_0040;
        tick("tmr_det");
        clear_commit();
        mstatus_ie_i = 1'b0;
        chk("tmr_mepc", wdata_mepc_o, 64'h8000_0040);
        tick("tmr_epc");
        chk("tmr_mcause", wdata_mcause_o, 64'h8000_0000_0000_0007);
        tick("tmr_cause");
        tick("tmr_status");
        tick("tmr_jump");
        commit_valid_i = 1'b1; commit_pc_i = 64'h8000_0044;
        #1;
        chk("ie0_no_stall", 64'(stall_o), 64'd0);
        tick("ie0_idle");
        set_idle();

        // --- Exception wins over coincident MRET ---
        commit_valid_i = 1'b1; exc_valid_i = 1'b1; exc_cause_i = 5'd11; mret_i = 1'b1;
        commit_pc_i = 64'h8000_0060; mepc_i = 64'h8000_0200;
        tick("excmret_det");
        clear_commit();
        tick("excmret_epc");
        chk("excmret_mcause", wdata_mcause_o, 64'hB);
        tick("excmret_cause");
        tick("excmret_status");
        tick("excmret_jump");

        // --- MRET alone ---
        commit_valid_i = 1'b1; mret_i = 1'b1;
        tick("mret_det");
        clear_commit();
        chk("mret_redir_v", 64'(redirect_valid_o), 64'd1);
        chk("mret_redir_pc", redirect_pc_o, 64'h8000_0200);
        chk("mret_restore", 64'(mret_restore_o), 64'd1);
        tick("mret_mret");
        chk("mret_idle", 64'(busy_o), 64'd0);

        // --- Asynchronous reset during CAUSE ---
        commit_valid_i = 1'b1; exc_valid_i = 1'b1; exc_cause_i = 5'd4;
        commit_pc_i = 64'h8000_0070;
        tick("rst_det");
        clear_commit();
        tick("rst_epc");
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        commit_valid_i = 1'b1; exc_valid_i = 1'b1; exc_cause_i = 5'd5;
        commit_pc_i = 64'h8000_0080;
        tick("post_rst_det");
        clear_commit();
        chk("post_rst_mepc", wdata_mepc_o, 64'h8000_0080);
        tick("post_rst_epc");
        tick("post_rst_cause");
        tick("post_rst_status");
        tick("post_rst_jump");
        chk("post_rst_idle", 64'(busy_o), 64'd0);

        // --- Back-to-back exceptions held continuously ---
        commit_valid_i = 1'b1; exc_valid_i = 1'b1; exc_cause_i = 5'd1;
        commit_pc_i = 64'h8000_0090;
        for (int i = 0; i < 15; i++) tick($sformatf("b2b_%0d", i));
        clear_commit();
        for (int i = 0; i < 6 && exp_q.size() != 0; i++) tick("b2b_drain");

        // --- Random traffic ---
        for (int i = 0; i < 400; i++) begin
            commit_valid_i = ($urandom_range(0, 9) < 7);
            exc_valid_i    = ($urandom_range(0, 4) == 0);
            exc_cause_i    = CAUSE_W'($urandom);
            mret_i         = ($urandom_range(0, 3) == 0);
            mstatus_ie_i   = 1'($urandom);
            mie_mtie_i     = 1'($urandom);
            mie_msie_i     = 1'($urandom);
            irq_timer_i    = 1'($urandom);
            irq_soft_i     = 1'($urandom);
            commit_pc_i    = {$urandom, $urandom};
            mtvec_i        = {$urandom, $urandom};
            mepc_i         = {$urandom, $urandom};
            tick($sformatf("rnd_%0d", i));
        end
        set_idle();
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick("rnd_drain");
        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
Trap/return sequencer for the machine-mode CSR file. It detects synchronous exceptions, pending timer/software interrupts and MRET at the commit boundary. It then drives the CSR file's dedicated write ports (mepc, mcause, exception MIE) in a fixed one-write-per-cycle sequence and issues a single PC redirect to the fetch stage. While the sequence runs, it stalls the pipeline and blocks instruction-originated CSR writes, which makes CSR write arbitration deterministic.

Parameters:
XLEN, 64, datapath / CSR width
CAUSE_W, 5, width of exception/interrupt cause code

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
commit_valid_i  input  1  an instruction is at the commit boundary this cycle
commit_pc_i  input  XLEN  PC of the committing instruction
exc_valid_i  input  1  committing instruction raised a synchronous exception
exc_cause_i  input  CAUSE_W  exception code
mret_i  input  1  committing instruction is MRET
mstatus_ie_i  input  1  mstatus.MIE from CSR file
mie_mtie_i  input  1  mie.MTIE
mie_msie_i  input  1  mie.MSIE
irq_timer_i  input  1  timer interrupt pending (level)
irq_soft_i  input  1  software interrupt pending (level)
mtvec_i  input  XLEN  trap vector from CSR file
mepc_i  input  XLEN  current mepc from CSR file
we_mepc_o  output  1  mepc write strobe
wdata_mepc_o  output  XLEN  mepc write data
we_mcause_o  output  1  mcause write strobe
wdata_mcause_o  output  XLEN  mcause write data: {intr, zeros, code}
exception_mie_req_o  output  1  mstatus IE-stack push request (IE1<=IE, IE<=0)
mret_restore_o  output  1  mstatus IE-stack pop request
csr_we_block_o  output  1  gates instruction CSR writes
stall_o  output  1  freeze pipeline
redirect_valid_o  output  1  one-cycle fetch redirect
redirect_pc_o  output  XLEN  redirect target
busy_o  output  1  FSM not in IDLE

Behaviour:
- States: IDLE, EPC, CAUSE, STATUS, JUMP, MRET. Encoding is implementation choice.
- Reset (rst=0, asynchronous, at any time including mid-sequence): state=IDLE and all registered outputs 0. Latched pc/cause are cleared to 0. Redirects and strobes already in flight are dropped.
- Trap-take condition, evaluated only in IDLE with commit_valid_i=1:
  - exc_valid_i=1 -> exception, code=exc_cause_i, intr=0.
  - Else, if mstatus_ie_i & mie_mtie_i & irq_timer_i -> intr=1, code=7.
  - Else, if mstatus_ie_i & mie_msie_i & irq_soft_i -> intr=1, code=3.
  - Priority: exception > timer > software.
- MRET-take: IDLE, commit_valid_i=1, mret_i=1, and no trap taken. If an exception and MRET coincide, the exception wins and the MRET is discarded.
- Detection cycle N (IDLE): stall_o=1 combinationally. Latch commit_pc_i, code and intr. Next state is EPC (trap) or MRET.
- Trap sequence:
  - N+1 EPC: we_mepc_o=1, wdata_mepc_o=latched pc.
  - N+2 CAUSE: we_mcause_o=1, wdata_mcause_o={intr, XLEN-1-CAUSE_W zeros, code}.
  - N+3 STATUS: exception_mie_req_o=1.
  - N+4 JUMP: redirect_valid_o=1, redirect_pc_o={mtvec_i[XLEN-1:2], 2'b00}.
  - N+5: IDLE.
- MRET sequence: N+1 MRET: redirect_valid_o=1, redirect_pc_o=mepc_i, mret_restore_o=1. N+2: IDLE.
- Exactly one CSR strobe is asserted per cycle. All strobes are 0 in IDLE.
- stall_o=1, csr_we_block_o=1 and busy_o=1 in every non-IDLE state.
- csr_we_block_o=0 and busy_o=0 in IDLE. stall_o in IDLE is 1 only on a detection cycle.
- Inputs other than mtvec_i and mepc_i are ignored outside IDLE. Exceptions, interrupts and MRET arriving mid-sequence are not queued; the stalled pipeline re-presents them.
- Interrupt levels are not latched. A pending bit that drops before detection is not taken.
- Back-to-back traps: the earliest next detection is at N+5 (IDLE). With interrupts pending and IE=0 after the push, no re-entry occurs.
- redirect_valid_o is high for exactly one cycle per sequence.
- No write data is ever taken from unlatched commit_* inputs after cycle N.

Test Plan:
- Reset, then exc_valid_i=1, exc_cause_i=2, commit_pc_i=0x8000_0010, mtvec_i=0x8000_0100:
  - N+1: we_mepc_o=1, wdata_mepc_o=0x8000_0010.
  - N+2: wdata_mcause_o=0x2.
  - N+3: exception_mie_req_o=1.
  - N+4: redirect to 0x8000_0100.
  - N+5: busy_o=0.
- mstatus_ie_i=1, mie_mtie_i=1, irq_timer_i=1 and irq_soft_i=1 with mie_msie_i=1, commit_pc_i=0x8000_0040 -> wdata_mcause_o=0x8000_0000_0000_0007 and mepc=0x8000_0040. With mstatus_ie_i=0 -> no trap, stall_o=0.
- mret_i and exc_valid_i (cause 11) in the same cycle -> trap sequence with cause 0xB, and mret_restore_o is never asserted.
- mret_i alone, mepc_i=0x8000_0200 -> N+1: redirect_valid_o=1, redirect_pc_o=0x8000_0200, mret_restore_o=1. N+2: IDLE.
- Drive rst=0 asynchronously during CAUSE -> all outputs 0 immediately. After release, the next exception runs a full 5-cycle sequence from EPC.
- Hold exc_valid_i=1 continuously -> a new sequence starts every 5 cycles. csr_we_block_o is high in the 4 non-IDLE cycles of each sequence and low only on the IDLE detection cycle.
